// File: rtl/maroc_sc_pkg.sv
// -----------------------------------------------------------------------------
// maroc_sc_pkg
// Shared definitions for the MAROC slow-control loader:
//   - sc_state_e     : loader FSM states
//   - MAROC3_FRAME_W : MAROC3 slow-control frame length in bits
//   - OFS_*          : bit offsets of the main fields inside the frame, used by
//                      the host-side frame assembly logic
//   - is_shifting()  : true in the states that drive CK_SC / D_SC
// -----------------------------------------------------------------------------
package maroc_sc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        LOAD   = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } sc_state_e;

    localparam int MAROC3_FRAME_W = 829;

    // Field offsets within the MAROC3 slow-control frame.
    localparam int OFS_DAC2  = 3;
    localparam int OFS_DAC1  = 13;
    localparam int OFS_MASK  = 27;
    localparam int OFS_GAIN  = 189;
    localparam int OFS_CTEST = 765;

    function automatic logic is_shifting(input sc_state_e s);
        return (s == LOAD) || (s == VERIFY);
    endfunction

endpackage

// File: rtl/maroc_sc_loader_clk_gen.sv
// -----------------------------------------------------------------------------
// sc_clk_gen
// Divided serial clock generator for the MAROC slow-control interface.
// While en_i is high a counter runs 0..CLK_DIV-1 and toggles the phase on
// every wrap, so one full CK_SC period is 2*CLK_DIV clk. The first half of
// every period is low. While en_i is low the divider is held at count 0,
// phase low, so the first enabled cycle always starts a fresh low phase.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   en_i     : run the divider
//   ck_o     : CK_SC level (the phase register)
//   rise_o   : strobe on the clk cycle whose edge raises ck_o
//   fall_o   : strobe on the clk cycle whose edge lowers ck_o (end of a bit)
// -----------------------------------------------------------------------------
module sc_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic ck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          wrap;

    assign wrap = en_i && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign ck_o   = phase_q;
    assign rise_o = wrap && !phase_q;
    assign fall_o = wrap && phase_q;

endmodule

// File: rtl/maroc_sc_loader.sv
// -----------------------------------------------------------------------------
// maroc_sc_loader
// MAROC slow-control loader. Latches a configuration frame on an accepted
// start, pulses RSTn_SC low, shifts the frame out on D_SC with a divided
// CK_SC and, when READBACK=1, shifts it a second time while comparing the
// chip's Q_SC against the expected bits.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   start      : load request (valid); accepted only when busy=0 in IDLE
//   frame      : configuration frame, sampled on the accepted start cycle
//   busy       : operation in progress (RST, LOAD, VERIFY)
//   done       : one-cycle pulse at the end of an operation
//   err        : readback mismatch seen, sticky until next accepted start
//   err_idx    : shift-order index of the first mismatching bit
//   sc_d       : D_SC serial data
//   sc_ck      : CK_SC, idle low
//   sc_rstn    : RSTn_SC, active low, idle high
//   sc_q       : Q_SC from the chip (asynchronous, synchronised here)
//   dbg_state  : current FSM state, for observation only
//
// Handshake: start acts as a valid strobe and "state is IDLE" as ready. A
// transfer happens on the clk edge where start=1 in IDLE; start at any other
// time (including the cycle showing done) is dropped without side effects.
// -----------------------------------------------------------------------------
module maroc_sc_loader
    import maroc_sc_pkg::*;
#(
    parameter int FRAME_W    = 829,
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 8,
    parameter int LSB_FIRST  = 1,
    parameter int READBACK   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [FRAME_W-1:0]         frame,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(FRAME_W)-1:0] err_idx,
    output logic                       sc_d,
    output logic                       sc_ck,
    output logic                       sc_rstn,
    input  logic                       sc_q,
    output logic [2:0]                 dbg_state
);

    localparam int IW = $clog2(FRAME_W);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    sc_state_e          state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [IW-1:0]      bit_q, bit_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic [1:0]         sync_q;
    logic               err_q, err_d;
    logic [IW-1:0]      idx_q, idx_d;

    logic               shifting;
    logic               ck, ck_rise, ck_fall;
    logic               sr_out;
    logic               last_bit;
    logic [FRAME_W-1:0] sr_rot;

    assign shifting = is_shifting(state_q);
    assign last_bit = (bit_q == IW'(FRAME_W - 1));

    sc_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (shifting),
        .ck_o   (ck),
        .rise_o (ck_rise),
        .fall_o (ck_fall)
    );

    // The register rotates rather than shifts so that after FRAME_W bits it
    // holds the original frame again, ready for the verify pass.
    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign sr_out = sr_q[0];
            assign sr_rot = {sr_q[0], sr_q[FRAME_W-1:1]};
        end else begin : g_msb
            assign sr_out = sr_q[FRAME_W-1];
            assign sr_rot = {sr_q[FRAME_W-2:0], sr_q[FRAME_W-1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        rcnt_d  = rcnt_q;
        err_d   = err_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = frame;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    rcnt_d  = '0;
                    bit_d   = '0;
                    state_d = RST;
                end
            end
            RST: begin
                if (rcnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d = LOAD;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            LOAD, VERIFY: begin
                // The chip clocks D_SC in on the CK_SC rise and presents the
                // oldest stored bit on Q_SC; on the verify pass that bit is
                // the one loaded first, i.e. logical bit bit_q.
                if (state_q == VERIFY && ck_rise && !err_q && (sync_q[1] != sr_out)) begin
                    err_d = 1'b1;
                    idx_d = bit_q;
                end
                if (ck_fall) begin
                    sr_d = sr_rot;
                    if (last_bit) begin
                        bit_d   = '0;
                        state_d = (state_q == LOAD && READBACK != 0) ? VERIFY : DONE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            rcnt_q  <= '0;
            sync_q  <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            rcnt_q  <= rcnt_d;
            sync_q  <= {sync_q[0], sc_q};
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    assign busy      = (state_q == RST) || shifting;
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign err_idx   = idx_q;
    assign sc_d      = shifting & sr_out;
    assign sc_ck     = ck;
    assign sc_rstn   = (state_q != RST);
    assign dbg_state = state_q;

endmodule
